// File: rtl/drf_pkg.sv
// Shared constants and TX state encoding for the drf_system port agent.
package drf_pkg;
    localparam int NIBBLE_W   = 4;
    localparam int HOLD_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } tx_state_e;
endpackage

// File: rtl/drf_port_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle.
module drf_port_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // The extra MSB separates the wrapped-full case from empty.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/drf_port_agent.sv
// Host-side agent for drf_system: paces host nibbles onto port_input and
// queues every distinct value seen on port_output for the host.
module drf_port_agent
    import drf_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NIBBLE_W-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [NIBBLE_W-1:0] port_input,
    input  logic [NIBBLE_W-1:0] port_output,
    output logic [NIBBLE_W-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                tx_busy,
    output logic                rx_overflow
);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);

    tx_state_e             state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_q, hold_d;
    logic [NIBBLE_W-1:0]   port_input_q, port_input_d;
    logic [NIBBLE_W-1:0]   tx_rdata;
    logic                  tx_full, tx_empty, tx_push, tx_pop;

    logic [NIBBLE_W-1:0]   sync1_q, sync2_q, last_q;
    logic                  overflow_q;
    logic                  rx_full, rx_empty, rx_change, rx_pop, rx_drop;

    assign tx_ready    = !tx_full;
    assign tx_push     = tx_valid && tx_ready;
    assign tx_busy     = (state_q == HOLD);
    assign port_input  = port_input_q;

    drf_port_fifo #(.WIDTH(NIBBLE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_push),
        .wdata_i (tx_data),
        .pop_i   (tx_pop),
        .rdata_o (tx_rdata),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    // A one-cycle hold never needs HOLD: the IDLE pop cycle is the whole hold.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        port_input_d = port_input_q;
        tx_pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    port_input_d = tx_rdata;
                    hold_d       = HOLD_LOAD;
                    state_d      = (HOLD_CYCLES > 1) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                hold_d = hold_q - 1'b1;
                if (hold_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            port_input_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            port_input_q <= port_input_d;
        end
    end

    assign rx_valid    = !rx_empty;
    assign rx_pop      = rx_valid && rx_ready;
    assign rx_change   = (sync2_q != last_q);
    assign rx_drop     = rx_change && rx_full && !rx_pop;
    assign rx_overflow = overflow_q;

    drf_port_fifo #(.WIDTH(NIBBLE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_change),
        .wdata_i (sync2_q),
        .pop_i   (rx_pop),
        .rdata_o (rx_data),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    // last_q tracks every change, even dropped ones, so a value is never reported twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q <= port_output;
            sync2_q <= sync1_q;
            if (rx_change) last_q <= sync2_q;
            if (rx_drop) overflow_q <= 1'b1;
        end
    end
endmodule

// File: doc/drf_port_agent.md
DRF_PORT_AGENT -- requirements
Module: drf_port_agent

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 4: clock cycles each nibble is held on port_input (legal 1..255).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: entries per TX and RX FIFO (power of two, >=2).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port tx_data  input  4  host nibble to send into drf_system.
REQ-006 The block SHALL have port tx_valid  input  1  tx_data valid.
REQ-007 The block SHALL have port tx_ready  output  1  TX FIFO can accept.
REQ-008 The block SHALL have port port_input  output  4  drives drf_system.port_input.
REQ-009 The block SHALL have port port_output  input  4  from drf_system.port_output.
REQ-010 The block SHALL have port rx_data  output  4  oldest captured output nibble.
REQ-011 The block SHALL have port rx_valid  output  1  rx_data valid.
REQ-012 The block SHALL have port rx_ready  input  1  host consumes rx_data.
REQ-013 The block SHALL have port tx_busy  output  1  high while in HOLD state.
REQ-014 The block SHALL have port rx_overflow  output  1  sticky: a captured nibble was dropped.

Function
REQ-015 TX write SHALL occur on a cycle with tx_valid && tx_ready; tx_ready SHALL equal !tx_fifo_full.
REQ-016 TX FSM SHALL have states IDLE and HOLD.
REQ-017 In IDLE with TX FIFO non-empty, the FSM SHALL pop one entry, register it onto port_input at that edge, load hold counter with HOLD_CYCLES-1, and enter HOLD.
REQ-018 In HOLD the counter SHALL decrement each cycle; at 0 the FSM SHALL return to IDLE, so each nibble is driven exactly HOLD_CYCLES cycles before the next may replace it.
REQ-019 A write into an empty TX FIFO SHALL appear on port_input 2 edges after acceptance (1 for FIFO write, 1 for pop/load).
REQ-020 port_input SHALL retain the last sent nibble indefinitely when the TX FIFO is empty.
REQ-021 tx_busy SHALL be 1 exactly when the FSM is in HOLD.
REQ-022 RX SHALL sample port_output through a 2-flop synchronizer and compare the synchronized value with a last_captured register.
REQ-023 When synchronized value != last_captured, the block SHALL update last_captured and push the value into the RX FIFO in the same cycle; equal values SHALL never be pushed.
REQ-024 If the RX FIFO is full and no pop occurs that cycle, the push SHALL be dropped, last_captured still updated, and rx_overflow set to 1 until reset.
REQ-025 Simultaneous push and pop on a full RX FIFO SHALL succeed without overflow; simultaneous push and pop on an empty FIFO SHALL make the pushed entry visible the next cycle.
REQ-026 rx_valid SHALL equal !rx_fifo_empty; pop SHALL occur on rx_valid && rx_ready; rx_data SHALL be the head entry, stable while rx_valid && !rx_ready.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-028 On rst_n low, asynchronously: port_input=0, FSM=IDLE, hold counter=0, both FIFOs empty, synchronizer and last_captured=0, rx_overflow=0, tx_busy=0, rx_valid=0.
REQ-029 tx_ready SHALL be 1 from the first edge after rst_n deasserts; reset mid-HOLD SHALL abandon the nibble and discard queued entries.

Structure
REQ-030 Package drf_pkg SHALL hold NIBBLE_W=4 and the TX FSM state enum (IDLE, HOLD).
REQ-031 One sub-module drf_port_fifo (parameterised width/depth, same reset) SHALL be instantiated twice, for TX and RX.

Verification
REQ-032 Write 0x3,0x5 back-to-back, HOLD_CYCLES=4 -> port_input=3 for 4 cycles starting 2 edges after first accept, then 5 for 4 cycles, then stays 5.
REQ-033 Write 5 nibbles with no drain, FIFO_DEPTH=4 -> tx_ready low after the 4th entry is queued behind the active nibble; all 5 appear in order.
REQ-034 Drive port_output 0->A->A->C, rx_ready=1 -> rx_data A then C, 2 pops total, rx_overflow=0.
REQ-035 rx_ready=0, port_output through 6 distinct values -> first 4 retained in order, rx_overflow=1 and stays 1.
REQ-036 RX FIFO full, new change and rx_ready=1 same cycle -> no overflow, new value becomes last entry.
REQ-037 Assert rst_n low mid-HOLD -> port_input=0, tx_busy=0, rx_valid=0 immediately, without a clock edge.
